// File: rtl/counter_scheduler_pkg.sv
// Shared constants, FSM encoding and preset/bit-order helpers for counter_scheduler.
package counter_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Preset that makes the carry fire after exactly len count cycles (len 0 = 16).
  function automatic logic [CNT_W-1:0] preset_for(input logic [CNT_W-1:0] len);
    return CNT_W'(5'd16 - {1'b0, len});
  endfunction

  // Converts between a [3:0] value and the counter's [0:3] (bit 0 = LSB) bus order.
  function automatic logic [CNT_W-1:0] bit_rev(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = {CNT_W{1'b0}};
    for (int i = 0; i < CNT_W; i++) begin
      r[i] = v[CNT_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_scheduler_if.sv
// Requester handshake plus shared-counter control bundle for counter_scheduler.
interface counter_scheduler_if
  import counter_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       req;
  logic [CNT_W*N_REQ-1:0] len;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   cnt_count;
  logic                   cnt_load;
  logic [0:CNT_W-1]       cnt_inp;
  logic [0:CNT_W-1]       cnt_out;
  logic                   cnt_carry;

  modport master (
    output req, len, cnt_out, cnt_carry,
    input  grant, done, busy, cnt_count, cnt_load, cnt_inp
  );

  modport slave (
    input  req, len, cnt_out, cnt_carry,
    output grant, done, busy, cnt_count, cnt_load, cnt_inp
  );
endinterface

// File: rtl/counter_scheduler_chk.sv
// Simulation checker: the counter must hold the loaded preset in the first RUN cycle.
module counter_scheduler_chk
  import counter_pkg::*;
(
  input logic             clock,
  input logic             clear,
  input logic [1:0]       state,
  input logic [CNT_W-1:0] cnt_val,
  input logic [CNT_W-1:0] preset
);

  logic [1:0] prev_r;

  // Previous-cycle state, used to spot the LOAD -> RUN transition.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) prev_r <= IDLE;
    else       prev_r <= state;
  end

  // Preset consistency on the first RUN cycle.
  always @(posedge clock) begin
    if (!clear && state == RUN && prev_r == LOAD) begin
      assert (cnt_val == preset)
        else $error("counter value %0d differs from preset %0d", cnt_val, preset);
    end
  end

endmodule

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan offsets from far to near so the nearest requester overwrites last.
  always_comb begin
    int sum;
    int j;
    valid = 1'b0;
    idx   = {IDX_W{1'b0}};
    sum   = 0;
    j     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      j   = (sum >= N_REQ) ? (sum - N_REQ) : sum;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end else begin
        valid = valid;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin scheduler timing intervals on one shared 4-bit loadable counter.
// Build option COUNTER_SCHED_ABORT_EN: dropping req[idx] during RUN aborts without done.
module counter_scheduler
  import counter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input logic               clock,
  input logic               clear,
  counter_scheduler_if.slave bus
);

  logic [1:0]       state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s, ptr_r, ptr_s, nxt_ptr_s, arb_idx_s;
  logic [CNT_W-1:0] len_r, len_s;
  logic             arb_valid_s;
  logic [N_REQ-1:0] grant_r, done_r, grant_s, done_s, onehot_s;
  logic             busy_r, cnt_count_r, cnt_load_r;
  logic             busy_s, cnt_count_s, cnt_load_s;
  logic [0:CNT_W-1] cnt_inp_r, cnt_inp_s;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_r),
    .valid (arb_valid_s),
    .idx   (arb_idx_s)
  );

  assign nxt_ptr_s = (int'(idx_r) == N_REQ - 1) ? {IDX_W{1'b0}} : (idx_r + 1'b1);

  // Next-state logic; len is latched only on the IDLE -> LOAD hand-off.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    len_s   = len_r;
    ptr_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) begin
          idx_s   = arb_idx_s;
          len_s   = bus.len[CNT_W*arb_idx_s +: CNT_W];
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: state_s = RUN;
      RUN: begin
`ifdef COUNTER_SCHED_ABORT_EN
        if (!bus.req[idx_r]) begin
          state_s = IDLE;
          ptr_s   = nxt_ptr_s;
        end else if (bus.cnt_carry) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
`else
        if (bus.cnt_carry) state_s = DONE;
        else               state_s = RUN;
`endif
      end
      DONE: begin
        ptr_s   = nxt_ptr_s;
        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Moore outputs computed from the next state so they can be registered.
  always_comb begin
    onehot_s    = {{(N_REQ-1){1'b0}}, 1'b1} << idx_s;
    grant_s     = (state_s != IDLE) ? onehot_s : {N_REQ{1'b0}};
    done_s      = (state_s == DONE) ? onehot_s : {N_REQ{1'b0}};
    busy_s      = (state_s != IDLE);
    cnt_load_s  = (state_s == LOAD);
    cnt_count_s = (state_s == RUN);
    cnt_inp_s   = (state_s == LOAD) ? bit_rev(preset_for(len_s)) : {CNT_W{1'b0}};
  end

  // State, latches and registered outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      ptr_r       <= {IDX_W{1'b0}};
      len_r       <= {CNT_W{1'b0}};
      grant_r     <= {N_REQ{1'b0}};
      done_r      <= {N_REQ{1'b0}};
      busy_r      <= 1'b0;
      cnt_count_r <= 1'b0;
      cnt_load_r  <= 1'b0;
      cnt_inp_r   <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      ptr_r       <= ptr_s;
      len_r       <= len_s;
      grant_r     <= grant_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
      cnt_count_r <= cnt_count_s;
      cnt_load_r  <= cnt_load_s;
      cnt_inp_r   <= cnt_inp_s;
    end
  end

  assign bus.grant     = grant_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;
  assign bus.cnt_count = cnt_count_r;
  assign bus.cnt_load  = cnt_load_r;
  assign bus.cnt_inp   = cnt_inp_r;

`ifndef SYNTHESIS
  counter_scheduler_chk u_chk (
    .clock   (clock),
    .clear   (clear),
    .state   (state_r),
    .cnt_val (bit_rev(bus.cnt_out)),
    .preset  (preset_for(len_r))
  );
`endif

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed self-checking bench for counter_scheduler with a behavioural 4-bit counter.
module tb_counter_scheduler;
  import counter_pkg::*;

  localparam int N = 4;

  logic clock;
  logic clear;
  logic [3:0] cval;
  int checks = 0;
  int failures = 0;

  counter_scheduler_if #(.N_REQ(N)) bus ();

  counter_scheduler #(.N_REQ(N)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared counter model: clear, load, count with carry at 15.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)              cval <= 4'd0;
    else if (bus.cnt_load)  cval <= bit_rev(bus.cnt_inp);
    else if (bus.cnt_count) cval <= cval + 4'd1;
    else                    cval <= cval;
  end
  assign bus.cnt_out   = bit_rev(cval);
  assign bus.cnt_carry = bus.cnt_count && (cval == 4'hf);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From cycle 0, step until done rises or maxc cycles elapse.
  task automatic run_until_done(input int maxc, output int cyc, output logic [N-1:0] dvec,
                                output logic [3:0] inp, output int ncount,
                                output logic [N-1:0] gseen);
    cyc = -1; dvec = '0; inp = 4'd0; ncount = 0; gseen = '0;
    for (int c = 1; c <= maxc && cyc < 0; c++) begin
      tick();
      gseen |= bus.grant;
      if (bus.cnt_load) inp = bit_rev(bus.cnt_inp);
      if (bus.cnt_count) ncount++;
      if (bus.done != '0) begin
        cyc  = c;
        dvec = bus.done;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ncount, n, abort_cyc;
    logic [N-1:0] dvec, gseen, g1, g2;
    logic [3:0] inp;
    logic abort_busy;
    int dcyc[5];
    logic [N-1:0] dv[5];
    logic [N-1:0] gv[5];
    int exp_cyc[5];
    logic [N-1:0] exp_v[5];

    clear = 1'b1;
    bus.req = '0;
    bus.len = '0;
    repeat (2) tick();
    check("rst_grant", bus.grant, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_load", bus.cnt_load, 0);
    check("rst_count", bus.cnt_count, 0);
    check("rst_inp", bit_rev(bus.cnt_inp), 0);
    clear = 1'b0;
    tick();
    check("idle_busy", bus.busy, 0);

    // Single request, len0=5
    bus.len = 16'h0005;
    bus.req = 4'b0001;
    tick();
    check("s1_grant", bus.grant, 4'b0001);
    check("s1_load", bus.cnt_load, 1);
    check("s1_inp", bit_rev(bus.cnt_inp), 11);
    check("s1_count", bus.cnt_count, 0);
    check("s1_busy", bus.busy, 1);
    for (int c = 2; c <= 6; c++) begin
      tick();
      check("s_run_count", bus.cnt_count, 1);
      check("s_run_done", bus.done, 0);
    end
    check("s6_carry", bus.cnt_carry, 1);
    tick();
    check("s7_done", bus.done, 4'b0001);
    check("s7_count", bus.cnt_count, 0);
    check("s7_grant", bus.grant, 4'b0001);
    bus.req = '0;
    tick();
    check("s8_busy", bus.busy, 0);
    check("s8_grant", bus.grant, 0);

    // Async clear mid-RUN, then restart
    bus.req = 4'b0001;
    repeat (4) tick();
    check("r4_count", bus.cnt_count, 1);
    clear = 1'b1;
    #1;
    check("rc_grant", bus.grant, 0);
    check("rc_busy", bus.busy, 0);
    check("rc_count", bus.cnt_count, 0);
    check("rc_done", bus.done, 0);
    tick();
    check("rc_done_hold", bus.done, 0);
    clear = 1'b0;
    tick();
    check("rr1_load", bus.cnt_load, 1);
    check("rr1_grant", bus.grant, 4'b0001);
    run_until_done(30, cyc, dvec, inp, ncount, gseen);
    check("rr_done_cyc", cyc, 6);
    check("rr_done_vec", dvec, 4'b0001);
    bus.req = '0;
    tick();

    // len0=0 -> 16 count cycles
    bus.len = 16'h0000;
    bus.req = 4'b0001;
    run_until_done(40, cyc, dvec, inp, ncount, gseen);
    check("l0_inp", inp, 0);
    check("l0_ncount", ncount, 16);
    check("l0_cyc", cyc, 18);
    check("l0_vec", dvec, 4'b0001);
    bus.req = '0;
    tick();

    // len0=1 -> preset 15, done at 3
    bus.len = 16'h0001;
    bus.req = 4'b0001;
    run_until_done(20, cyc, dvec, inp, ncount, gseen);
    check("l1_inp", inp, 15);
    check("l1_ncount", ncount, 1);
    check("l1_cyc", cyc, 3);
    bus.req = '0;
    tick();

    // Round-robin from ptr 0, all len=2
    clear = 1'b1;
    bus.len = 16'h2222;
    bus.req = 4'b1111;
    tick();
    clear = 1'b0;
    exp_cyc = '{4, 9, 14, 19, 24};
    exp_v   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      dcyc[i] = -1; dv[i] = '0; gv[i] = '0;
    end
    n = 0;
    for (int c = 1; c <= 30 && n < 5; c++) begin
      tick();
      if (bus.done != '0) begin
        dcyc[n] = c;
        dv[n]   = bus.done;
        gv[n]   = bus.grant;
        n++;
        if (n == 5) bus.req = '0;
      end
    end
    check("rr_events", n, 5);
    for (int i = 0; i < 5; i++) begin
      check("rr_cyc", dcyc[i], exp_cyc[i]);
      check("rr_vec", dv[i], exp_v[i]);
      check("rr_grant", gv[i], exp_v[i]);
    end
    bus.req = '0;
    tick();

    // Move ptr to 2 via requester 1, then req=0011 must pick 0 then 1
    bus.len = 16'h0011;
    bus.req = 4'b0010;
    run_until_done(20, cyc, dvec, inp, ncount, gseen);
    check("f0_vec", dvec, 4'b0010);
    bus.req = 4'b0011;
    tick();
    run_until_done(20, cyc, dvec, inp, ncount, g1);
    check("f1_vec", dvec, 4'b0001);
    check("f1_cyc", cyc, 3);
    check("f1_gseen", g1, 4'b0001);
    bus.req = 4'b0010;
    tick();
    run_until_done(20, cyc, dvec, inp, ncount, g2);
    check("f2_vec", dvec, 4'b0010);
    check("f2_no_req2", (g1 | g2) & 4'b0100, 0);
    bus.req = '0;
    tick();

    // Drop req1 at third RUN cycle, len1=8
    bus.len = 16'h0080;
    bus.req = 4'b0010;
    repeat (4) tick();
    check("ab4_count", bus.cnt_count, 1);
    bus.req = '0;
    abort_cyc = -1;
    abort_busy = 1'b1;
    for (int c = 5; c <= 20; c++) begin
      tick();
      if (c == 5) abort_busy = bus.busy;
      if (bus.done != '0 && abort_cyc < 0) begin
        abort_cyc = c;
        dvec = bus.done;
      end
    end
`ifdef COUNTER_SCHED_ABORT_EN
    check("ab_busy5", abort_busy, 0);
    check("ab_no_done", abort_cyc, -1);
`else
    check("ab_busy5", abort_busy, 1);
    check("ab_done_cyc", abort_cyc, 10);
    check("ab_done_vec", dvec, 4'b0010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_scheduler.md
Name: counter_scheduler

Overview:
- Shares one 4-bit loadable up-counter (count/load/inp/out/carry interface) between N_REQ requesters, each asking for a timed interval of len cycles.
- Arbitrates round-robin and loads the preset that makes the counter's carry fire after exactly len count cycles.
- Runs the count and returns a one-cycle done pulse to the winner.
- Sits beside the counter instance; the counter's clear is tied to the same clear net.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(N_REQ), derived width of the grant index; not to be overridden.

Ports:
- clock  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-high reset.
- req  input  N_REQ  level request per requester; held until done.
- len  input  4*N_REQ  requested interval per requester, nibble i = len[4*i+3:4*i]; 1..15 = cycles, 0 = 16 cycles.
- grant  output  N_REQ  one-hot; winner's bit high from LOAD through DONE.
- done  output  N_REQ  one-cycle pulse on winner's bit at interval end.
- busy  output  1  high whenever state != IDLE.
- cnt_count  output  1  drives counter count enable.
- cnt_load  output  1  drives counter load.
- cnt_inp  output  [0:3]  preset to counter; bit 0 is LSB.
- cnt_out  input  [0:3]  counter value; bit 0 is LSB.
- cnt_carry  input  1  counter carry: count & out==4'b1111.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer = 0 (requester 0 has highest priority first). Async clear mid-interval aborts immediately; no done is issued.
- FSM (registered state; Moore outputs):
  - IDLE: if |req, pick the first requester at or after ptr (wrapping), latch idx and len[idx], go to LOAD. Else stay.
  - LOAD: cnt_load=1, cnt_count=0, cnt_inp = (16 - L) mod 16, where L is the latched len. len 0 gives preset 0. Go to RUN.
  - RUN: cnt_count=1, cnt_load=0. When cnt_carry=1, go to DONE.
  - DONE: done[idx]=1, cnt_count=0, ptr = idx+1 mod N_REQ, go to IDLE.
- Latency: req seen in IDLE at cycle 0 → LOAD cycle 1 → RUN cycles 2..L+1 (carry on cycle L+1) → DONE cycle L+2. The next grant can start at cycle L+3.
- grant is asserted in LOAD, RUN and DONE. busy = grant != 0.
- len is sampled only in IDLE. Later changes have no effect on the current interval.
- Deasserting req during RUN is ignored (the interval completes) unless the optional feature is compiled in.
- Counter wraps 15 → 0 on the carry cycle. cnt_out is not used for control; it is exposed for checking only.
- Sanity check: if cnt_out != preset in the first RUN cycle, raise a simulation-only $error. No RTL effect.

Optional Feature:
- COUNTER_SCHED_ABORT_EN defined: in RUN, if req[idx] falls, go to IDLE next cycle with no done pulse. ptr still advances.
- COUNTER_SCHED_ABORT_EN undefined: the req drop is ignored and the interval runs to done.

Decomposition:
- Package counter_pkg holds:
  - CNT_W = 4.
  - State encoding: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3.
  - Function preset_for(len) = (16 - len) mod 16.
- One sub-module, rr_arbiter. Inputs: req and ptr. Outputs: valid and idx. Purely combinational.
- The FSM and latches stay in counter_scheduler.

Test Plan:
- Reset mid-RUN: len0=5, assert clear at cycle 4 → all outputs 0 asynchronously, no done; after release, req0 restarts from LOAD.
- Single request: req=0001, len0=5 → LOAD with cnt_inp=11 at cycle 1, cnt_count high cycles 2..6, carry at 6, done=0001 at cycle 7, busy low at 8.
- len=0 and len=1: len0=0 → preset 0, 16 count cycles, done at cycle 18. len0=1 → preset 15, carry on first RUN cycle, done at cycle 3.
- Round-robin: req=1111, all len=2 → grant order 0,1,2,3,0, with each done 5 cycles apart (IDLE, LOAD, RUN×2, DONE).
- Fairness after skip: ptr=2, req=0011 → requester 0 granted, then requester 1. Requester 2 is never granted while its req=0.
- Abort: with COUNTER_SCHED_ABORT_EN, len1=8, drop req1 at RUN cycle 3 → IDLE next cycle, no done. Without the macro → done at cycle 10.
